// File: rtl/amba_master.sv
// amba_master: APB-style initiator turning valid/ready commands into
// SETUP/ACCESS bus transfers with a single-cycle response pulse.
// Optional ACCESS wait timeout: define AMBA_MASTER_TIMEOUT_EN.
module amba_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PnR_W,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // Elaboration guard on the timeout range
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("amba_master: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pnr_w;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    state_t                w_state_nxt;
    logic                  w_cmd_ready;
    logic                  w_psel;
    logic                  w_penable;
    logic                  w_pnr_w;
    logic [ADDR_WIDTH-1:0] w_paddr;
    logic [DATA_WIDTH-1:0] w_pwdata;
    logic                  w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_rdata;
    logic                  w_rsp_err;

`ifdef AMBA_MASTER_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt;
`endif

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_pnr_w     = r_pnr_w;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b0;
`ifdef AMBA_MASTER_TIMEOUT_EN
        w_wait_cnt  = r_wait_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = S_SETUP;
                    w_cmd_ready = 1'b0;
                    w_psel      = 1'b1;
                    w_pnr_w     = cmd_write;
                    w_paddr     = cmd_addr;
                    w_pwdata    = cmd_wdata;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
                w_psel      = 1'b1;
                w_penable   = 1'b1;
`ifdef AMBA_MASTER_TIMEOUT_EN
                w_wait_cnt  = 8'd0;
`endif
            end
            S_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = r_pnr_w ? '0 : PRDATA;
                end else begin
`ifdef AMBA_MASTER_TIMEOUT_EN
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else begin
                        w_psel     = 1'b1;
                        w_penable  = 1'b1;
                        w_wait_cnt = r_wait_cnt + 8'd1;
                    end
`else
                    w_psel    = 1'b1;
                    w_penable = 1'b1;
`endif
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_cmd_ready = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cmd_ready = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer at once
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pnr_w     <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef AMBA_MASTER_TIMEOUT_EN
            r_wait_cnt  <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pnr_w     <= w_pnr_w;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
`ifdef AMBA_MASTER_TIMEOUT_EN
            r_wait_cnt  <= w_wait_cnt;
`endif
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PnR_W     = r_pnr_w;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_amba_master.sv
// tb_amba_master: table vectors, random transfers against a transaction
// timeline model, plus hand sequences for reset, back-to-back and timeout.
module tb_amba_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PnR_W;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;

    amba_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PnR_W    (PnR_W),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Values the bus fields must hold since the last accepted command
    logic          exp_pnr_w  = 1'b0;
    logic [AW-1:0] exp_paddr  = '0;
    logic [DW-1:0] exp_pwdata = '0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] rdata;
        int            gap;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, DW'(act), DW'(exp));
    endtask

    task automatic expect_bus(input string tag, input logic psel, input logic pen,
                              input logic rdy, input logic rv);
        check1($sformatf("%s.PSEL", tag), PSEL, psel);
        check1($sformatf("%s.PENABLE", tag), PENABLE, pen);
        check1($sformatf("%s.cmd_ready", tag), cmd_ready, rdy);
        check1($sformatf("%s.rsp_valid", tag), rsp_valid, rv);
    endtask

    task automatic expect_fields(input string tag);
        check1($sformatf("%s.PnR_W", tag), PnR_W, exp_pnr_w);
        check32($sformatf("%s.PADDR", tag), DW'(PADDR), DW'(exp_paddr));
        check32($sformatf("%s.PWDATA", tag), PWDATA, exp_pwdata);
    endtask

    task automatic drive_garbage(input logic valid);
        cmd_valid = valid;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        PREADY    = 1'($urandom);
        PRDATA    = $urandom;
    endtask

    // One transfer: gap idle cycles, accept (j=0), SETUP (j=1),
    // ACCESS (j=2..2+waits), response pulse (j=3+waits)
    task automatic run_txn(input vec_t v);
        for (int g = 0; g < v.gap; g++) begin
            @(negedge PCLK);
            expect_bus("gap", 1'b0, 1'b0, 1'b1, 1'b0);
            expect_fields("gap");
            check32("gap.rsp_rdata", rsp_rdata, '0);
            check1("gap.rsp_err", rsp_err, 1'b0);
            drive_garbage(1'b0);
        end
        @(negedge PCLK);
        expect_bus("accept", 1'b0, 1'b0, 1'b1, 1'b0);
        check32("accept.rsp_rdata", rsp_rdata, '0);
        PRESET    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        PREADY    = 1'($urandom);
        PRDATA    = $urandom;
        exp_pnr_w  = v.wr;
        exp_paddr  = v.addr;
        exp_pwdata = v.wdata;
        for (int j = 1; j <= 3 + v.waits; j++) begin
            bit in_acc;
            bit is_resp;
            @(negedge PCLK);
            in_acc  = (j >= 2) && (j <= 2 + v.waits);
            is_resp = (j == 3 + v.waits);
            expect_bus($sformatf("txn.j%0d", j), (j <= 2 + v.waits), in_acc, 1'b0, is_resp);
            expect_fields($sformatf("txn.j%0d", j));
            if (is_resp) begin
                check32("rsp.rdata", rsp_rdata, v.exp_rdata);
                check1("rsp.err", rsp_err, 1'b0);
            end
            drive_garbage(1'($urandom));
            if (in_acc) PREADY = (j == 2 + v.waits);
            if (j == 2 + v.waits) PRDATA = v.rdata;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int acc1;
        int acc2;
        int cyc;
        int bad;
        vec_t rv;

        vecs[0] = '{1'b1, 2'd1, 32'h72,       0,      32'hDEAD,     0, 32'h0};
        vecs[1] = '{1'b0, 2'd3, 32'h1111,     4,      32'hAF,       2, 32'hAF};
        vecs[2] = '{1'b0, 2'd0, 32'h0,        0,      32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 1,     32'h1234,     1, 32'h0};
        vecs[4] = '{1'b0, 2'd2, 32'h0,        int'(TO) - 1, 32'h600D_F00D, 0, 32'h600D_F00D};
        vecs[5] = '{1'b1, 2'd2, 32'h0,        3,      32'hBAD,      0, 32'h0};

        // Reset held for 3 edges with a command pending
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (i > 0) begin
                expect_bus("reset", 1'b0, 1'b0, 1'b1, 1'b0);
                check1("reset.rsp_err", rsp_err, 1'b0);
            end
            PRESET    = 1'b0;
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 2'd1;
            cmd_wdata = 32'h72;
            PREADY    = 1'b1;
        end

        // Table vectors; the first is accepted on the first edge after reset release
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Random transfers
        for (int i = 0; i < 40; i++) begin
            rv.wr        = 1'($urandom);
            rv.addr      = AW'($urandom);
            rv.wdata     = $urandom;
            rv.waits     = int'($urandom_range(0, 6));
            rv.rdata     = $urandom;
            rv.gap       = int'($urandom_range(0, 2));
            rv.exp_rdata = rv.wr ? '0 : rv.rdata;
            run_txn(rv);
        end

        // Back-to-back: write then read with cmd_valid held high
        @(negedge PCLK);
        check1("b2b.ready0", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 32'h35;
        PREADY = 1'b1; PRDATA = 32'h5A5A_0F0F;
        acc1 = 0; acc2 = -1; cyc = 0;
        while (acc2 < 0 && cyc < 10) begin
            @(negedge PCLK);
            cyc++;
            if (cyc == 1) begin
                check1("b2b.setup_psel", PSEL, 1'b1);
                check32("b2b.PWDATA", PWDATA, 32'h35);
                cmd_write = 1'b0; cmd_addr = 2'd2; cmd_wdata = 32'h0;
            end
            if (cyc == 3) begin
                check1("b2b.rsp1", rsp_valid, 1'b1);
                check32("b2b.rsp1_rdata", rsp_rdata, '0);
            end
            if (cmd_ready) begin
                acc2 = cyc;
                check1("b2b.no_overlap", PSEL, 1'b0);
            end
        end
        check32("b2b.interval", DW'(acc2 - acc1), DW'(4));
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check1("b2b.psel2", PSEL, 1'b1);
        check1("b2b.PnR_W2", PnR_W, 1'b0);
        check32("b2b.PADDR2", DW'(PADDR), DW'(2));
        @(negedge PCLK);
        @(negedge PCLK);
        check1("b2b.rsp2", rsp_valid, 1'b1);
        check32("b2b.rsp2_rdata", rsp_rdata, 32'h5A5A_0F0F);
        exp_pnr_w = 1'b0; exp_paddr = 2'd2; exp_pwdata = 32'h0;

        // Stuck PREADY: timeout with the feature, endless ACCESS without it
        @(negedge PCLK);
        check1("to.ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1; cmd_wdata = 32'h0;
        PREADY = 1'b0; PRDATA = 32'hCAFE_BABE;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        expect_bus("to.setup", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef AMBA_MASTER_TIMEOUT_EN
        bad = 0;
        for (int j = 0; j < int'(TO); j++) begin
            @(negedge PCLK);
            if (PENABLE !== 1'b1 || PSEL !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        check32("to.access_cycles_bad", DW'(bad), '0);
        @(negedge PCLK);
        expect_bus("to.resp", 1'b0, 1'b0, 1'b0, 1'b1);
        check1("to.err", rsp_err, 1'b1);
        check32("to.rdata", rsp_rdata, '0);
        @(negedge PCLK);
        expect_bus("to.idle", 1'b0, 1'b0, 1'b1, 1'b0);
        check1("to.err_clear", rsp_err, 1'b0);
`else
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge PCLK);
            if (PENABLE !== 1'b1 || PSEL !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) bad++;
        end
        check32("to.stuck_cycles_bad", DW'(bad), '0);
        PRESET = 1'b0;
        @(negedge PCLK);
        expect_bus("to.reset", 1'b0, 1'b0, 1'b1, 1'b0);
        PRESET = 1'b1;
`endif
        exp_pnr_w = 1'b0; exp_paddr = 2'd1;

        // Reset in the middle of ACCESS
        @(negedge PCLK);
        check1("mid.ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 32'h99;
        PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check1("mid.access", PENABLE, 1'b1);
        @(negedge PCLK);
        check1("mid.access2", PENABLE, 1'b1);
        PRESET = 1'b0;
        @(negedge PCLK);
        expect_bus("mid.reset", 1'b0, 1'b0, 1'b1, 1'b0);
        check32("mid.PADDR", DW'(PADDR), '0);
        check32("mid.PWDATA", PWDATA, '0);
        PRESET = 1'b1; PREADY = 1'b1;
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || cmd_ready !== 1'b1) bad++;
            drive_garbage(1'b0);
        end
        check32("mid.no_rsp_bad", DW'(bad), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
